// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding and hazard control block:
// forwarding-mux select encodings and the pipeline slot records.
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Slot records hold register addresses zero-extended to this width, so any
  // REG_AW up to SLOT_AW shares one record layout.
  localparam int SLOT_AW = 8;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } slot_t;

  // MEM and WB only need to know who writes what.
  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
  } wr_slot_t;

  function automatic logic writes_reg(input wr_slot_t s, input logic [SLOT_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Priority forwarding comparator for one ALU operand: MEM beats WB beats
// the register file; x0 never forwards.
module fwd_sel_logic
  import fwd_hazard_unit_pkg::*;
(
  input  logic [SLOT_AW-1:0] src_i,
  input  wr_slot_t           mem_i,
  input  wr_slot_t           wb_i,
  output logic [1:0]         sel_o
);

  // NOTE: give every combinational output a default first so no path through
  // the block leaves it unassigned and a latch gets inferred.
  always_comb begin
    sel_o = FWD_RF;
    if (writes_reg(mem_i, src_i)) begin
      sel_o = FWD_MEM;
    end else if (writes_reg(wb_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding selects, load-use stall and branch flush for the 5-stage
// core, driven from shadow EX/MEM/WB slot records, plus saturating event counters.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              br_taken,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_t              ex_q, ex_d;
  logic [SLOT_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [SLOT_AW-1:0] ex_rs2_q, ex_rs2_d;
  wr_slot_t           mem_q, wb_q;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic [SLOT_AW-1:0] id_rs1_w, id_rs2_w, id_rd_w;
  logic               load_hz;

  assign id_rs1_w = SLOT_AW'(id_rs1);
  assign id_rs2_w = SLOT_AW'(id_rs2);
  assign id_rd_w  = SLOT_AW'(id_rd);

  // Conservative: rs2 is compared even when the ID instruction ignores it.
  assign load_hz = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid
                && ((id_rs1_w == ex_q.rd) || (id_rs2_w == ex_q.rd));

  always_comb begin
    stall    = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    ex_d     = '{valid: id_valid, rd: id_rd_w, reg_write: id_reg_write,
                 mem_read: id_mem_read};
    ex_rs1_d = id_rs1_w;
    ex_rs2_d = id_rs2_w;
    if (br_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_hz) begin
      stall    = 1'b1;
      flush_ex = 1'b1;
    end
    // A bubble is an all-zero record: its x0 sources can never select a forward.
    if (br_taken || load_hz) begin
      ex_d     = '0;
      ex_rs1_d = '0;
      ex_rs2_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      // The back end advances every cycle; a stall only freezes PC and IF/ID.
      mem_q    <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      wb_q     <= mem_q;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_id && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  fwd_sel_logic u_fwd_a (
    .src_i (ex_rs1_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (fwd_a_sel)
  );

  fwd_sel_logic u_fwd_b (
    .src_i (ex_rs2_q),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .sel_o (fwd_b_sel)
  );

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: an instruction-level pipeline model
// checked every cycle, plus directed sequences with hand-computed expectations.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, br_taken;

  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, flush_id, flush_ex;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
  logic        s_stall, s_flush_id, s_flush_ex;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_err    = 0;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .br_taken(br_taken), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .br_taken(br_taken), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .stall(s_stall), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t ex_m, mem_m, wb_m;
  int   stall_n, flush_n;
  bit   model_known = 0;

  function automatic bit produces(input ins_t s, input int r);
    return s.v && s.rw && (s.rd != 0) && (s.rd == r);
  endfunction

  function automatic int exp_sel(input int r);
    if (produces(mem_m, r)) return 2;
    if (produces(wb_m, r))  return 1;
    return 0;
  endfunction

  function automatic bit model_hz();
    return ex_m.v && ex_m.mr && (ex_m.rd != 0) && id_valid
        && ((int'(id_rs1) == ex_m.rd) || (int'(id_rs2) == ex_m.rd));
  endfunction

  function automatic int sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ex_m = '{default: 0};
      mem_m = '{default: 0};
      wb_m = '{default: 0};
      stall_n = 0;
      flush_n = 0;
      model_known = 1;
    end else if (model_known) begin
      bit hz;
      hz = model_hz();
      if (br_taken) flush_n++;
      else if (hz)  stall_n++;
      wb_m  = mem_m;
      mem_m = ex_m;
      if (br_taken || hz) ex_m = '{default: 0};
      else ex_m = '{v: id_valid, rs1: int'(id_rs1), rs2: int'(id_rs2), rd: int'(id_rd),
                    rw: id_reg_write, mr: id_mem_read};
    end
  end

  always @(negedge clk) begin
    if (model_known) begin
      bit hz;
      hz = model_hz();
      check("fwd_a_sel", 32'(fwd_a_sel), exp_sel(ex_m.rs1));
      check("fwd_b_sel", 32'(fwd_b_sel), exp_sel(ex_m.rs2));
      check("stall",     32'(stall),     32'(!br_taken && hz));
      check("flush_id",  32'(flush_id),  32'(br_taken));
      check("flush_ex",  32'(flush_ex),  32'(br_taken || hz));
      check("stall_cnt", 32'(stall_cnt), sat(stall_n, 16));
      check("flush_cnt", 32'(flush_cnt), sat(flush_n, 16));
      check("sat_fwd_a_sel", 32'(s_fwd_a_sel), exp_sel(ex_m.rs1));
      check("sat_stall",     32'(s_stall),     32'(!br_taken && hz));
      check("sat_stall_cnt", 32'(s_stall_cnt), sat(stall_n, 4));
      check("sat_flush_cnt", 32'(s_flush_cnt), sat(flush_n, 4));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input bit st, input bit fi, input bit fe);
    check({tag, "_a"},  32'(fwd_a_sel), 32'(a));
    check({tag, "_b"},  32'(fwd_b_sel), 32'(b));
    check({tag, "_st"}, 32'(stall),     32'(st));
    check({tag, "_fi"}, 32'(flush_id),  32'(fi));
    check({tag, "_fe"}, 32'(flush_ex),  32'(fe));
  endtask

  initial begin
    rst = 1'b1;
    br_taken = 1'b0;
    drive(1, 5, 5, 6, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nop();

    // Reset state over three idle cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ctl("reset", 2'b00, 2'b00, 0, 0, 0);
      check("reset_stall_cnt", 32'(stall_cnt), 0);
      check("reset_flush_cnt", 32'(flush_cnt), 0);
      tick();
    end

    // EX-to-EX forward: add x5; sub x6,x5,x5
    drive(1, 1, 2, 5, 1, 0); tick();
    drive(1, 5, 5, 6, 1, 0); tick();
    nop(); @(negedge clk); check_ctl("fwd_mem", 2'b10, 2'b10, 0, 0, 0); tick();

    // One intervening nop -> WB forward
    drive(1, 1, 2, 5, 1, 0); tick();
    nop(); tick();
    drive(1, 5, 5, 6, 1, 0); tick();
    nop(); @(negedge clk); check_ctl("fwd_wb", 2'b01, 2'b01, 0, 0, 0); tick();

    // Two nops -> regfile
    drive(1, 1, 2, 5, 1, 0); tick();
    nop(); tick();
    nop(); tick();
    drive(1, 5, 5, 6, 1, 0); tick();
    nop(); @(negedge clk); check_ctl("fwd_rf", 2'b00, 2'b00, 0, 0, 0); tick();

    // Back-to-back writers of x7: younger (MEM) wins
    drive(1, 1, 2, 7, 1, 0); tick();
    drive(1, 3, 4, 7, 1, 0); tick();
    drive(1, 7, 7, 8, 1, 0); tick();
    nop(); @(negedge clk); check_ctl("prio", 2'b10, 2'b10, 0, 0, 0); tick();

    // Same sequence on x0: never forwarded
    drive(1, 1, 2, 0, 1, 0); tick();
    drive(1, 3, 4, 0, 1, 0); tick();
    drive(1, 0, 0, 8, 1, 0); tick();
    nop(); @(negedge clk); check_ctl("x0", 2'b00, 2'b00, 0, 0, 0); tick();

    // Load-use: lw x3; add x4,x3,x1 -> one stall, then WB forward on A
    drive(1, 1, 0, 3, 1, 1); tick();
    drive(1, 3, 1, 4, 1, 0);
    @(negedge clk); check_ctl("lu_stall", 2'b00, 2'b00, 1, 0, 1);
    check("lu_cnt0", 32'(stall_cnt), 0);
    tick();
    @(negedge clk); check_ctl("lu_clear", 2'b00, 2'b00, 0, 0, 0);
    check("lu_cnt1", 32'(stall_cnt), 1);
    tick();
    nop(); @(negedge clk); check_ctl("lu_fwd", 2'b01, 2'b00, 0, 0, 0); tick();

    // Branch taken over a pending load hazard: flush only
    drive(1, 1, 0, 3, 1, 1); tick();
    drive(1, 3, 0, 9, 1, 0); br_taken = 1'b1;
    @(negedge clk); check_ctl("br", 2'b00, 2'b00, 0, 1, 1);
    tick();
    br_taken = 1'b0; nop();
    @(negedge clk);
    check("br_flush_cnt", 32'(flush_cnt), 1);
    check("br_stall_cnt", 32'(stall_cnt), 1);
    check("br_no_stall", 32'(stall), 0);
    tick();

    // 20 load hazards: a self-dependent load held in ID stalls every other cycle
    drive(1, 3, 3, 3, 1, 1);
    repeat (40) tick();
    nop(); @(negedge clk);
    check("sat_main_cnt", 32'(stall_cnt), 21);
    check("sat_4b_cnt", 32'(s_stall_cnt), 15);
    check("sat_4b_flush", 32'(s_flush_cnt), 1);
    tick();

    // Reset mid-operation discards in-flight writers of x5
    drive(1, 1, 2, 5, 1, 0); tick();
    drive(1, 1, 2, 5, 1, 0); tick();
    drive(1, 5, 5, 6, 1, 0); rst = 1'b1; tick();
    rst = 1'b0; drive(1, 5, 5, 6, 1, 0); tick();
    nop(); @(negedge clk);
    check_ctl("rst_mid", 2'b00, 2'b00, 0, 0, 0);
    check("rst_mid_scnt", 32'(stall_cnt), 0);
    check("rst_mid_fcnt", 32'(flush_cnt), 0);
    tick();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
